// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port 4K x 16 synchronous memory between the CPU
//            (port 0) and the program loader / debug port (port 1). Each port
//            uses a req/gnt handshake. An owner keeps the memory for at most
//            MAX_BURST consecutive beats while the other port is waiting. Read
//            data returns one cycle after the beat.
// Ports    : clk, reset (sync, active-high)
//            req0/1, we0/1, addr0/1, wdata0/1 : requester side inputs
//            gnt0/1, rvalid0/1, rdata0/1      : requester side outputs
//            mem_en, mem_we, mem_addr, mem_wdata : memory macro controls
//            mem_rdata : memory read data, valid one cycle after a read strobe
// Config   : `define ARB_RR_EN -> when both ports request from IDLE, the port
//            that did not own the last beat wins (round-robin). Undefined ->
//            port 0 always wins that tie. The burst limit applies in both
//            builds.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int DWIDTH     = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DWIDTH-1:0]     wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0]     wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DWIDTH-1:0]     rdata0,
  output logic [DWIDTH-1:0]     rdata1,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0]     mem_wdata,
  input  logic [DWIDTH-1:0]     mem_rdata
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             last_owner_q, last_owner_d;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;

  logic             w_beat0;
  logic             w_beat1;
  logic             w_tie_to1;

  // A beat is the owner holding its request. Reset blocks the beat so the
  // memory never sees a strobe while the arbiter is being cleared.
  assign w_beat0 = req0 & (state_q == OWN0) & ~reset;
  assign w_beat1 = req1 & (state_q == OWN1) & ~reset;

`ifdef ARB_RR_EN
  assign w_tie_to1 = ~last_owner_q;
`else
  // last_owner is still tracked so the round-robin build differs only in
  // this tie-break. Here it has no effect.
  assign w_tie_to1 = 1'b0 & last_owner_q;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic: ownership and burst counting
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        burst_cnt_d = '0;
        if (req0 && req1) begin
          state_d = w_tie_to1 ? OWN1 : OWN0;
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!req0) begin
          burst_cnt_d = '0;
          state_d     = req1 ? OWN1 : IDLE;
        end else if (burst_cnt_q == C_CNT_LAST) begin
          // Burst limit reached. Hand over only if port 1 is waiting.
          // Otherwise restart the count without leaving OWN0.
          burst_cnt_d = '0;
          if (req1) begin
            state_d = OWN1;
          end
        end else begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
      OWN1: begin
        if (!req1) begin
          burst_cnt_d = '0;
          state_d     = req0 ? OWN0 : IDLE;
        end else if (burst_cnt_q == C_CNT_LAST) begin
          burst_cnt_d = '0;
          if (req0) begin
            state_d = OWN0;
          end
        end else begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Beat side-effects: last owner and read-response tracking
  // --------------------------------------------------------------------------
  always_comb begin
    last_owner_d = last_owner_q;
    if (w_beat0) begin
      last_owner_d = 1'b0;
    end else if (w_beat1) begin
      last_owner_d = 1'b1;
    end
    rvalid0_d = w_beat0 & ~we0;
    rvalid1_d = w_beat1 & ~we1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      last_owner_q <= 1'b1;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_owner_q <= last_owner_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign gnt0 = (state_q == OWN0);
  assign gnt1 = (state_q == OWN1);

  // A reset arriving in the cycle after a read beat cancels that response.
  assign rvalid0 = rvalid0_q & ~reset;
  assign rvalid1 = rvalid1_q & ~reset;
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

  assign mem_en    = w_beat0 | w_beat1;
  assign mem_we    = (w_beat0 & we0) | (w_beat1 & we1);
  assign mem_addr  = w_beat0 ? addr0  : (w_beat1 ? addr1  : '0);
  assign mem_wdata = w_beat0 ? wdata0 : (w_beat1 ? wdata1 : '0);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. The bench drives one cycle at
//            a time and compares every cycle against a reference model of the
//            arbitration rules (owner, beat count, pending reads). Directed
//            table rows and hand-built sequences also carry their own expected
//            values. A randomized phase follows, checked by the model alone.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [11:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.DWIDTH(16), .ADDR_WIDTH(12), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory macro behaviour: synchronous write, registered read.
  logic [15:0] mem [4096];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // Reference model state
  logic [15:0] ref_mem [4096];
  int          m_owner;        // 0, 1, or 2 = nobody
  int          m_cnt;          // beats taken in the current ownership
  int          m_last;
  bit          m_rv [2];
  logic [15:0] m_rvd [2];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst, r0, w0;
    logic [11:0] a0;
    logic [15:0] d0;
    logic        r1, w1;
    logic [11:0] a1;
    logic [15:0] d1;
    bit          tab;
    logic        g0, g1, en, we;
    logic [11:0] addr;
    logic        rv0, rv1;
    logic [15:0] rd;
  } vec_t;

  function automatic vec_t mk(logic rst, logic r0, logic w0, logic [11:0] a0, logic [15:0] d0,
                              logic r1, logic w1, logic [11:0] a1, logic [15:0] d1,
                              logic g0, logic g1, logic en, logic we, logic [11:0] addr,
                              logic rv0, logic rv1, logic [15:0] rd);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.tab = 1'b1; v.g0 = g0; v.g1 = g1; v.en = en; v.we = we; v.addr = addr;
    v.rv0 = rv0; v.rv1 = rv1; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare at mid-cycle, then advance the model.
  task automatic step(input vec_t v);
    logic        e_we;
    logic [11:0] e_addr;
    logic [15:0] e_wd;
    bit          beat, rq0, rq1;
    int          o;
    reset = v.rst; req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    #3;
    o      = m_owner;
    beat   = !v.rst && (o == 0 ? v.r0 : (o == 1 ? v.r1 : 1'b0));
    e_we   = beat && (o == 0 ? v.w0 : v.w1);
    e_addr = beat ? (o == 0 ? v.a0 : v.a1) : 12'h000;
    e_wd   = beat ? (o == 0 ? v.d0 : v.d1) : 16'h0000;
    chk("gnt0", gnt0, o == 0);
    chk("gnt1", gnt1, o == 1);
    chk("mem_en", mem_en, beat);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("rvalid0", rvalid0, m_rv[0] && !v.rst);
    chk("rvalid1", rvalid1, m_rv[1] && !v.rst);
    if (m_rv[0] && !v.rst) chk("rdata0", rdata0, m_rvd[0]);
    if (m_rv[1] && !v.rst) chk("rdata1", rdata1, m_rvd[1]);
    if (v.tab) begin
      chk("tab_gnt0", gnt0, v.g0);
      chk("tab_gnt1", gnt1, v.g1);
      chk("tab_mem_en", mem_en, v.en);
      chk("tab_mem_we", mem_we, v.we);
      chk("tab_mem_addr", mem_addr, v.addr);
      chk("tab_rvalid0", rvalid0, v.rv0);
      chk("tab_rvalid1", rvalid1, v.rv1);
      if (v.rv0) chk("tab_rdata0", rdata0, v.rd);
      if (v.rv1) chk("tab_rdata1", rdata1, v.rd);
    end
    @(posedge clk);
    if (v.rst) begin
      m_owner = 2; m_cnt = 0; m_last = 1; m_rv[0] = 0; m_rv[1] = 0;
    end else begin
      m_rv[0] = beat && o == 0 && !e_we;
      m_rv[1] = beat && o == 1 && !e_we;
      if (beat) begin
        if (e_we) ref_mem[e_addr] = e_wd;
        else      m_rvd[o] = ref_mem[e_addr];
        m_last = o;
      end
      rq0 = v.r0; rq1 = v.r1;
      if (o == 2) begin
        m_cnt = 0;
        if (rq0 && rq1) begin
`ifdef ARB_RR_EN
          m_owner = 1 - m_last;
`else
          m_owner = 0;
`endif
        end else if (rq0) m_owner = 0;
        else if (rq1)     m_owner = 1;
      end else if (!(o == 0 ? rq0 : rq1)) begin
        m_cnt   = 0;
        m_owner = (o == 0 ? rq1 : rq0) ? 1 - o : 2;
      end else begin
        m_cnt++;
        if (m_cnt == MB) begin
          m_cnt = 0;
          if (o == 0 ? rq1 : rq0) m_owner = 1 - o;
        end
      end
    end
    #1;
  endtask

  vec_t tab [18];
  vec_t v;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 16'h0000; ref_mem[i] = 16'h0000;
    end
    mem[12'h010] = 16'hBEEF; ref_mem[12'h010] = 16'hBEEF;
    mem[12'h020] = 16'h1234; ref_mem[12'h020] = 16'h1234;
    m_owner = 2; m_cnt = 0; m_last = 1;
    m_rv[0] = 0; m_rv[1] = 0; m_rvd[0] = '0; m_rvd[1] = '0;

    //            rst r0 w0 a0      d0       r1 w1 a1      d1        g0 g1 en we addr    rv0 rv1 rd
    tab[0]  = mk(0, 1, 0, 12'h010, 16'h0,   0, 0, 12'h0,  16'h0,    0, 0, 0, 0, 12'h0,   0, 0, 16'h0);
    tab[1]  = mk(0, 1, 0, 12'h010, 16'h0,   0, 0, 12'h0,  16'h0,    1, 0, 1, 0, 12'h010, 0, 0, 16'h0);
    tab[2]  = mk(0, 0, 0, 12'h0,   16'h0,   0, 0, 12'h0,  16'h0,    1, 0, 0, 0, 12'h0,   1, 0, 16'hBEEF);
    tab[3]  = mk(0, 0, 0, 12'h0,   16'h0,   1, 1, 12'h123,16'hA5A5, 0, 0, 0, 0, 12'h0,   0, 0, 16'h0);
    tab[4]  = mk(0, 0, 0, 12'h0,   16'h0,   1, 1, 12'h123,16'hA5A5, 0, 1, 1, 1, 12'h123, 0, 0, 16'h0);
    tab[5]  = mk(0, 1, 0, 12'h123, 16'h0,   0, 0, 12'h0,  16'h0,    0, 1, 0, 0, 12'h0,   0, 0, 16'h0);
    tab[6]  = mk(0, 1, 0, 12'h123, 16'h0,   0, 0, 12'h0,  16'h0,    1, 0, 1, 0, 12'h123, 0, 0, 16'h0);
    tab[7]  = mk(0, 0, 0, 12'h0,   16'h0,   0, 0, 12'h0,  16'h0,    1, 0, 0, 0, 12'h0,   1, 0, 16'hA5A5);
    tab[8]  = mk(0, 1, 0, 12'h010, 16'h0,   0, 0, 12'h0,  16'h0,    0, 0, 0, 0, 12'h0,   0, 0, 16'h0);
    tab[9]  = mk(0, 1, 0, 12'h010, 16'h0,   1, 0, 12'h020,16'h0,    1, 0, 1, 0, 12'h010, 0, 0, 16'h0);
    tab[10] = mk(0, 1, 0, 12'h011, 16'h0,   1, 0, 12'h020,16'h0,    1, 0, 1, 0, 12'h011, 1, 0, 16'hBEEF);
    tab[11] = mk(0, 0, 0, 12'h0,   16'h0,   1, 0, 12'h020,16'h0,    1, 0, 0, 0, 12'h0,   1, 0, 16'h0000);
    tab[12] = mk(0, 0, 0, 12'h0,   16'h0,   1, 0, 12'h020,16'h0,    0, 1, 1, 0, 12'h020, 0, 0, 16'h0);
    tab[13] = mk(0, 0, 0, 12'h0,   16'h0,   0, 0, 12'h0,  16'h0,    0, 1, 0, 0, 12'h0,   0, 1, 16'h1234);
    tab[14] = mk(0, 1, 0, 12'h010, 16'h0,   0, 0, 12'h0,  16'h0,    0, 0, 0, 0, 12'h0,   0, 0, 16'h0);
    tab[15] = mk(0, 1, 0, 12'h010, 16'h0,   0, 0, 12'h0,  16'h0,    1, 0, 1, 0, 12'h010, 0, 0, 16'h0);
    tab[16] = mk(1, 1, 0, 12'h010, 16'h0,   0, 0, 12'h0,  16'h0,    1, 0, 0, 0, 12'h0,   0, 0, 16'h0);
    tab[17] = mk(0, 0, 0, 12'h0,   16'h0,   0, 0, 12'h0,  16'h0,    0, 0, 0, 0, 12'h0,   0, 0, 16'h0);

    // Bring the DUT out of its unknown power-up state before any comparison.
    reset = 1'b1; req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    @(posedge clk); #1;
    v = mk(1, 0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, 0, 0, 0, 0, 12'h0, 0, 0, 16'h0);
    step(v);

    for (int i = 0; i < 18; i++) step(tab[i]);

    // Both ports held: four beats each, alternating, with no idle cycle.
    for (int k = 0; k < 10; k++) begin
      logic g0, g1;
      g0 = (k >= 1 && k <= 4) || k == 9;
      g1 = (k >= 5 && k <= 8);
      v = mk(0, 1, 0, 12'h100 + 12'(k), 16'h0, 1, 0, 12'h200 + 12'(k), 16'h0,
             g0, g1, g0 | g1, 0, g0 ? 12'h100 + 12'(k) : (g1 ? 12'h200 + 12'(k) : 12'h0),
             k >= 2 && k <= 5, k >= 6, 16'h0);
      step(v);
    end
    // Port 0 owned last; both request again from IDLE.
    v = mk(0, 0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, 1, 0, 0, 0, 12'h0, 1, 0, 16'h0);
    step(v);
    v = mk(0, 1, 0, 12'h110, 16'h0, 1, 0, 12'h210, 16'h0, 0, 0, 0, 0, 12'h0, 0, 0, 16'h0);
    step(v);
`ifdef ARB_RR_EN
    v = mk(0, 1, 0, 12'h110, 16'h0, 1, 0, 12'h210, 16'h0, 0, 1, 1, 0, 12'h210, 0, 0, 16'h0);
    step(v);
    v = mk(0, 0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, 0, 1, 0, 0, 12'h0, 0, 1, 16'h0);
    step(v);
`else
    v = mk(0, 1, 0, 12'h110, 16'h0, 1, 0, 12'h210, 16'h0, 1, 0, 1, 0, 12'h110, 0, 0, 16'h0);
    step(v);
    v = mk(0, 0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, 1, 0, 0, 0, 12'h0, 1, 0, 16'h0);
    step(v);
`endif

    // Randomized traffic over a small address window so reads hit writes.
    for (int n = 0; n < 3000; n++) begin
      v.rst = ($urandom_range(0, 99) == 0);
      v.r0  = ($urandom_range(0, 3) != 0);
      v.w0  = $urandom_range(0, 1) != 0;
      v.a0  = 12'h300 + 12'($urandom_range(0, 15));
      v.d0  = 16'($urandom);
      v.r1  = ($urandom_range(0, 2) != 0);
      v.w1  = $urandom_range(0, 1) != 0;
      v.a1  = 12'h300 + 12'($urandom_range(0, 15));
      v.d1  = 16'($urandom);
      v.tab = 1'b0;
      step(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
